// File: rtl/ppu_pkg.sv
// Shared PPU definitions: default widths, the transparent colour and interrupt bit indices.
package ppu_pkg;

  localparam int unsigned RGB_BIT_DEF     = 12;
  localparam int unsigned POS_BIT_DEF     = 10;
  localparam int unsigned TRANSPARENT_RGB = 0;
  localparam int unsigned IRQ_FRAME       = 0;
  localparam int unsigned IRQ_LINE        = 1;

endpackage

// File: rtl/ppu_irq_ctrl.sv
// Raster event edge detection, sticky pending bits, masking and the registered irq line.
// Build option: PPU_LINE_IRQ_EN enables the raster-line interrupt (pending bit IRQ_LINE).
module ppu_irq_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned POS_BIT = POS_BIT_DEF,
  parameter int unsigned LAST_X  = 639,
  parameter int unsigned LAST_Y  = 479
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pos_live,
  input  logic [POS_BIT-1:0] pos_x,
  input  logic [POS_BIT-1:0] pos_y,
  input  logic [POS_BIT-1:0] line_cfg,
  input  logic [1:0]         mask,
  input  logic [1:0]         clr,
  output logic [1:0]         pending,
  output logic               frame_end,
  output logic               irq
);

`ifdef PPU_LINE_IRQ_EN
  localparam logic [1:0] ImplMask = 2'b11;
`else
  // Line interrupt not built: its event, clear and mask bits are all forced off.
  localparam logic [1:0] ImplMask = 2'b01;
`endif

  logic [1:0] evt, evt_q, armed_q, rise;
  logic [1:0] pending_q, pending_d;
  logic       frame_end_q, irq_q;

  // Level events on the stage-1 position and their qualified rising edges.
  always_comb begin
    evt            = '0;
    evt[IRQ_FRAME] = (pos_x == POS_BIT'(LAST_X)) && (pos_y == POS_BIT'(LAST_Y));
    evt[IRQ_LINE]  = (pos_x == POS_BIT'(LAST_X)) && (pos_y == line_cfg) &&
                     (line_cfg <= POS_BIT'(LAST_Y));
    evt            = evt & ImplMask;
    // An event only counts as rising once it has been seen low on real pixel data.
    rise           = evt & ~evt_q & armed_q;
    // Set wins over clear of the same bit.
    pending_d      = (rise | (pending_q & ~clr)) & ImplMask;
  end

  // Edge history, arming, pending bits, frame pulse and the masked irq register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_q       <= '0;
      armed_q     <= '0;
      pending_q   <= '0;
      frame_end_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      evt_q       <= evt;
      armed_q     <= armed_q | ({2{pos_live}} & ~evt);
      pending_q   <= pending_d;
      frame_end_q <= rise[IRQ_FRAME];
      irq_q       <= |(pending_q & mask & ImplMask);
    end
  end

  assign pending   = pending_q;
  assign frame_end = frame_end_q;
  assign irq       = irq_q;

endmodule

// File: rtl/ppu_layer_mixer.sv
// Two-stage priority mixer of PPU pixel layers plus frame/line raster interrupts.
// Build option: PPU_LINE_IRQ_EN enables the raster-line interrupt in ppu_irq_ctrl.
module ppu_layer_mixer
  import ppu_pkg::*;
#(
  parameter int unsigned LAYER_NUM = 3,
  parameter int unsigned RGB_BIT   = RGB_BIT_DEF,
  parameter int unsigned POS_BIT   = POS_BIT_DEF,
  parameter int unsigned LAST_X    = 639,
  parameter int unsigned LAST_Y    = 479
) (
  input  logic                         vga_clk,
  input  logic                         rstn,
  input  logic [LAYER_NUM*RGB_BIT-1:0] layer_rgb,
  input  logic [LAYER_NUM-1:0]         layer_en,
  input  logic [POS_BIT-1:0]           pix_x,
  input  logic [POS_BIT-1:0]           pix_y,
  input  logic                         pix_valid,
  output logic [RGB_BIT-1:0]           mix_rgb,
  output logic                         mix_valid,
  output logic [$clog2(LAYER_NUM)-1:0] mix_layer,
  input  logic [POS_BIT-1:0]           irq_line_cfg,
  input  logic [1:0]                   irq_mask,
  input  logic [1:0]                   irq_clr,
  output logic [1:0]                   irq_pending,
  output logic                         frame_end,
  output logic                         irq
);

  localparam int unsigned LayerW = $clog2(LAYER_NUM);

  logic [LAYER_NUM*RGB_BIT-1:0] s1_rgb_q;
  logic [LAYER_NUM-1:0]         s1_en_q;
  logic [POS_BIT-1:0]           s1_x_q, s1_y_q;
  logic                         s1_valid_q;
  // High once stage 1 holds a real pixel since reset release.
  logic                         s1_live_q;

  logic [RGB_BIT-1:0]           win_rgb;
  logic [LayerW-1:0]            win_layer;

  // Stage 1: register all pixel inputs.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      s1_rgb_q   <= '0;
      s1_en_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_live_q  <= 1'b0;
    end else begin
      s1_rgb_q   <= layer_rgb;
      s1_en_q    <= layer_en;
      s1_x_q     <= pix_x;
      s1_y_q     <= pix_y;
      s1_valid_q <= pix_valid;
      s1_live_q  <= 1'b1;
    end
  end

  // Highest-index enabled opaque layer wins; otherwise fall back to the backdrop.
  always_comb begin
    win_rgb   = s1_en_q[0] ? s1_rgb_q[RGB_BIT-1:0] : '0;
    win_layer = '0;
    for (int unsigned i = 1; i < LAYER_NUM; i++) begin
      if (s1_en_q[i] && (s1_rgb_q[i*RGB_BIT +: RGB_BIT] != RGB_BIT'(TRANSPARENT_RGB))) begin
        win_rgb   = s1_rgb_q[i*RGB_BIT +: RGB_BIT];
        win_layer = LayerW'(i);
      end
    end
    if (!s1_valid_q) begin
      win_rgb   = '0;
      win_layer = '0;
    end
  end

  // Stage 2: register the mixed pixel.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      mix_rgb   <= '0;
      mix_layer <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_rgb   <= win_rgb;
      mix_layer <= win_layer;
      mix_valid <= s1_valid_q;
    end
  end

  ppu_irq_ctrl #(
    .POS_BIT (POS_BIT),
    .LAST_X  (LAST_X),
    .LAST_Y  (LAST_Y)
  ) u_irq_ctrl (
    .clk       (vga_clk),
    .rstn      (rstn),
    .pos_live  (s1_live_q),
    .pos_x     (s1_x_q),
    .pos_y     (s1_y_q),
    .line_cfg  (irq_line_cfg),
    .mask      (irq_mask),
    .clr       (irq_clr),
    .pending   (irq_pending),
    .frame_end (frame_end),
    .irq       (irq)
  );

endmodule

// File: tb/tb_ppu_layer_mixer.sv
// Randomized self-checking bench for ppu_layer_mixer against a cycle-level reference model.
// Honours PPU_LINE_IRQ_EN the same way the design does.
module tb_ppu_layer_mixer;
  import ppu_pkg::*;

  localparam int LN = 3;
  localparam int RB = RGB_BIT_DEF;
  localparam int PB = POS_BIT_DEF;
  localparam int LX = 639;
  localparam int LY = 479;
  localparam int LW = $clog2(LN);
`ifdef PPU_LINE_IRQ_EN
  localparam bit LineOn = 1'b1;
`else
  localparam bit LineOn = 1'b0;
`endif

  logic            vga_clk = 1'b0;
  logic            rstn;
  logic [LN*RB-1:0] layer_rgb;
  logic [LN-1:0]   layer_en;
  logic [PB-1:0]   pix_x, pix_y, irq_line_cfg;
  logic            pix_valid;
  logic [RB-1:0]   mix_rgb;
  logic            mix_valid;
  logic [LW-1:0]   mix_layer;
  logic [1:0]      irq_mask, irq_clr, irq_pending;
  logic            frame_end, irq;

  ppu_layer_mixer #(
    .LAYER_NUM (LN),
    .RGB_BIT   (RB),
    .POS_BIT   (PB),
    .LAST_X    (LX),
    .LAST_Y    (LY)
  ) u_dut (
    .vga_clk      (vga_clk),
    .rstn         (rstn),
    .layer_rgb    (layer_rgb),
    .layer_en     (layer_en),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_valid    (pix_valid),
    .mix_rgb      (mix_rgb),
    .mix_valid    (mix_valid),
    .mix_layer    (mix_layer),
    .irq_line_cfg (irq_line_cfg),
    .irq_mask     (irq_mask),
    .irq_clr      (irq_clr),
    .irq_pending  (irq_pending),
    .frame_end    (frame_end),
    .irq          (irq)
  );

  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expected outputs plus the pixel applied on the previous edge.
  logic [RB-1:0]    e_rgb;
  logic             e_valid;
  logic [LW-1:0]    e_layer;
  logic [1:0]       e_pend;
  logic             e_irq, e_fe;
  logic [LN*RB-1:0] p_rgb;
  logic [LN-1:0]    p_en;
  logic             p_valid;
  logic [PB-1:0]    p_x, p_y;
  bit               have_prev, seen_eval, prev_ef, prev_el;

  function automatic void ref_mix(input logic [LN*RB-1:0] rgb, input logic [LN-1:0] en,
                                  input logic v, output logic [RB-1:0] c,
                                  output logic [LW-1:0] l);
    c = '0;
    l = '0;
    if (!v) return;
    for (int i = LN - 1; i >= 1; i--) begin
      if (en[i] && rgb[i*RB +: RB] != '0) begin
        c = rgb[i*RB +: RB];
        l = LW'(i);
        return;
      end
    end
    if (en[0]) c = rgb[RB-1:0];
  endfunction

  // Predict the DUT state after the coming rising edge, given the inputs now applied.
  task automatic model_edge();
    bit ef, el, rf, rl;
    if (!rstn) begin
      e_rgb = '0; e_valid = 1'b0; e_layer = '0; e_pend = '0; e_irq = 1'b0; e_fe = 1'b0;
      have_prev = 0; seen_eval = 0; prev_ef = 0; prev_el = 0;
      return;
    end
    rf = 0;
    rl = 0;
    if (have_prev) begin
      ef = (int'(p_x) == LX) && (int'(p_y) == LY);
      el = LineOn && (int'(p_x) == LX) && (p_y == irq_line_cfg) && (int'(irq_line_cfg) <= LY);
      // A rise needs the previous evaluated pixel to have shown the event low.
      rf = ef && seen_eval && !prev_ef;
      rl = el && seen_eval && !prev_el;
      seen_eval = 1;
      prev_ef   = ef;
      prev_el   = el;
    end
    e_irq  = |(e_pend & irq_mask);
    e_pend = {rl, rf} | (e_pend & ~irq_clr);
    e_fe   = rf;
    if (have_prev) ref_mix(p_rgb, p_en, p_valid, e_rgb, e_layer);
    else begin e_rgb = '0; e_layer = '0; end
    e_valid   = have_prev && p_valid;
    p_rgb     = layer_rgb;
    p_en      = layer_en;
    p_valid   = pix_valid;
    p_x       = pix_x;
    p_y       = pix_y;
    have_prev = 1;
  endtask

  task automatic compare_all();
    check("mix_rgb",     mix_rgb,     e_rgb);
    check("mix_valid",   mix_valid,   e_valid);
    check("mix_layer",   mix_layer,   e_layer);
    check("irq_pending", irq_pending, e_pend);
    check("frame_end",   frame_end,   e_fe);
    check("irq",         irq,         e_irq);
  endtask

  // Inputs are set at a falling edge; this models the next rising edge and checks after it.
  task automatic step();
    model_edge();
    @(negedge vga_clk);
    compare_all();
  endtask

  task automatic set_pos(input int x, input int y);
    pix_x = PB'(x);
    pix_y = PB'(y);
  endtask

  int fe_cnt;
  int r;

  initial begin
    rstn = 1'b0; layer_rgb = '0; layer_en = '0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    irq_line_cfg = '0; irq_mask = '0; irq_clr = '0;
    @(negedge vga_clk);
    step();
    step();

    // Priority mix: layer 1 beats backdrop, transparent layer 2 ignored.
    rstn = 1'b1; irq_mask = 2'b01;
    layer_rgb = {12'h000, 12'hF00, 12'h0F0}; layer_en = 3'b111; pix_valid = 1'b1; set_pos(5, 5);
    step();
    step();
    check("prio_rgb",   mix_rgb,   12'hF00);
    check("prio_layer", mix_layer, 1);

    // Disabled and enabled backdrop.
    layer_rgb = '0; layer_en = 3'b110;
    step(); step();
    check("bd_off_rgb", mix_rgb, 0);
    layer_rgb = {24'h0, 12'h00F}; layer_en = 3'b111;
    step(); step();
    check("bd_on_rgb",   mix_rgb,   12'h00F);
    check("bd_on_layer", mix_layer, 0);

    // Frame pulse with the position held for four cycles.
    set_pos(LX, LY - 1); step();
    fe_cnt = 0;
    set_pos(LX, LY);
    for (int i = 0; i < 4; i++) begin step(); fe_cnt += int'(frame_end); end
    set_pos(1, 1);
    for (int i = 0; i < 2; i++) begin step(); fe_cnt += int'(frame_end); end
    check("frame_pulse_cnt", fe_cnt, 1);
    check("frame_pending",   irq_pending, 2'b01);
    check("frame_irq",       irq, 1);
    irq_clr = 2'b01; step(); irq_clr = 2'b00; step();

    // Line interrupt from a scan around row 100, then clear colliding with a new event.
    irq_line_cfg = 10'd100; irq_mask = 2'b11;
    for (int y = 98; y <= 102; y++)
      for (int x = LX - 2; x <= LX; x++) begin set_pos(x, y); step(); end
    check("line_pending", irq_pending[1], LineOn);
    set_pos(0, 0); step();
    set_pos(LX, 100); step();
    irq_clr = 2'b10; set_pos(0, 0); step();
    irq_clr = 2'b00;
    check("line_set_prio", irq_pending[1], LineOn);

    // Row-0 line config scan; only stays clear without the line interrupt built.
    irq_clr = 2'b11; step(); irq_clr = 2'b00;
    irq_line_cfg = '0;
    for (int x = LX - 2; x <= LX; x++) begin set_pos(x, 0); step(); end
    step();
    check("row0_pending", irq_pending[1], LineOn);

    // Reset mid-frame with the position parked at the frame event.
    set_pos(LX, LY); rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    fe_cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); fe_cnt += int'(frame_end); end
    check("rst_no_pulse", fe_cnt, 0);
    set_pos(0, 0); step();
    set_pos(LX, LY); step(); step();
    check("rst_then_pulse", frame_end, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < LN; i++)
        layer_rgb[i*RB +: RB] = ($urandom_range(0, 2) == 0) ? '0 : RB'($urandom);
      layer_en  = LN'($urandom);
      pix_valid = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r <= 3) set_pos(LX, LY);
      else if (r <= 5) set_pos(LX, int'(irq_line_cfg));
      else if (r == 9) set_pos(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      irq_clr = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 19) == 0) irq_mask = 2'($urandom);
      if ($urandom_range(0, 49) == 0) irq_line_cfg = PB'($urandom_range(0, 600));
      rstn = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_layer_mixer.md
PPU_LAYER_MIXER -- requirements
Module: ppu_layer_mixer

Interface
REQ-001 SHALL have parameter LAYER_NUM, default 3, number of pixel layers (2..4); layer 0 is the lowest-priority backdrop.
REQ-002 SHALL have parameter RGB_BIT, default 12, width of one layer colour.
REQ-003 SHALL have parameter POS_BIT, default 10, width of the raster coordinates.
REQ-004 SHALL have parameters LAST_X, default 639, and LAST_Y, default 479, giving the last visible pixel of the frame.
REQ-005 SHALL have ports vga_clk in 1, the only clock; rstn in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports layer_rgb in LAYER_NUM*RGB_BIT, layer colours with layer i at bits [i*RGB_BIT +: RGB_BIT]; layer_en in LAYER_NUM, per-layer enable.
REQ-007 SHALL have ports pix_x in POS_BIT and pix_y in POS_BIT, raster position; pix_valid in 1, pixel inside the game window.
REQ-008 SHALL have ports mix_rgb out RGB_BIT, mixed colour; mix_valid out 1, delayed pix_valid; mix_layer out $clog2(LAYER_NUM), winning layer index.
REQ-009 SHALL have ports irq_line_cfg in POS_BIT, raster-line interrupt row; irq_mask in 2; irq_clr in 2; irq_pending out 2 (bit0 frame, bit1 line); frame_end out 1, one-cycle pulse; irq out 1.

Function
REQ-010 SHALL register layer_rgb, layer_en, pix_valid, pix_x and pix_y in stage 1.
REQ-011 SHALL compute mix_rgb/mix_layer in stage 2 as the highest-index layer with layer_en=1 and colour !=0 (0 = transparent).
REQ-012 SHALL output layer 0 colour and mix_layer=0 when no layer is opaque, or 0 if layer_en[0]=0.
REQ-013 SHALL force mix_rgb=0 and mix_layer=0 when the stage-2 valid is 0.
REQ-014 SHALL have a fixed latency of 2 vga_clk cycles from inputs to mix_rgb, mix_layer and mix_valid.
REQ-015 SHALL flag the frame event when the stage-1 position equals (LAST_X, LAST_Y), and SHALL raise frame_end for exactly one cycle on the event's rising edge, even if the position is held for several cycles.
REQ-016 SHALL flag the line event when the stage-1 position equals (LAST_X, irq_line_cfg), with the same rising-edge rule; irq_line_cfg > LAST_Y never fires.
REQ-017 SHALL set irq_pending[n] on event n, where n=0 is frame and n=1 is line, and SHALL keep it sticky until irq_clr[n]=1.
REQ-018 SHALL give set priority when a set and a clear of the same bit occur in the same cycle.
REQ-019 SHALL drive irq as a register equal to |(irq_pending & irq_mask), one cycle after pending or mask changes.
REQ-020 SHALL have frame and line events at the same position set both bits in the same cycle.

Reset
REQ-021 SHALL clear, while rstn=0, all pipeline registers, mix_rgb, mix_valid, mix_layer, irq_pending, irq, frame_end and the edge-detect history.
REQ-022 SHALL discard in-flight pixels on reset mid-frame, and SHALL NOT generate a spurious frame_end on release even if the position is already at (LAST_X, LAST_Y); the edge history is reset to 0, but the event must first be seen low.

Configuration
REQ-023 SHALL, with PPU_LINE_IRQ_EN defined, implement the line event, irq_pending[1] and irq_line_cfg as specified.
REQ-024 SHALL, without PPU_LINE_IRQ_EN, tie irq_pending[1] to 0, ignore irq_line_cfg, irq_clr[1] and irq_mask[1], and leave port widths unchanged.

Structure
REQ-025 SHALL take from shared package ppu_pkg: the default RGB_BIT and POS_BIT, the TRANSPARENT_RGB constant (0), and the IRQ_FRAME=0 / IRQ_LINE=1 bit indices.
REQ-026 SHALL place event edge detection, pending, mask and irq generation in sub-module ppu_irq_ctrl, instantiated once.

Verification
REQ-027 SHALL cover priority mixing: LAYER_NUM=3, layer_rgb={12'h000,12'hF00,12'h0F0}, en=3'b111, valid=1 -> 2 cycles later mix_rgb=12'hF00, mix_layer=1.
REQ-028 SHALL cover disabled backdrop: all layers 0 and layer_en[0]=0 -> mix_rgb=0; with layer_en[0]=1 and layer0=12'h00F -> 12'h00F, mix_layer=0.
REQ-029 SHALL cover the frame pulse: position held at (639,479) for 4 cycles -> frame_end high exactly 1 cycle, irq_pending=2'b01, irq=1 next cycle with mask=2'b01.
REQ-030 SHALL cover the line interrupt: irq_line_cfg=100, raster scan -> irq_pending[1] set at (639,100); irq_clr=2'b10 on the same cycle as a new event -> bit stays 1.
REQ-031 SHALL cover reset: rstn low during a frame with position at (639,479) at release -> all outputs 0, no frame_end until the event is next seen low then high.
REQ-032 SHALL cover the build without PPU_LINE_IRQ_EN: irq_line_cfg=0 and a scan through row 0 -> irq_pending[1] stays 0, irq only from bit 0.
